// File: rtl/lif_neuron_loader_pkg.sv
// Shared definitions for the LIF neuron loader.
//   state_t   : loader FSM states
//   BYTES     : byte count of the default 32-synapse configuration
//   byte_sel  : byte k of a word, MSB first, for a word of nbytes bytes
package lif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    RUN,
    DONE
  } state_t;

  localparam int unsigned BYTES      = 4;
  localparam int unsigned MAX_INPUTS = 512;

  // Callers zero-extend their word to MAX_INPUTS so one helper serves
  // every INPUTS setting up to that limit.
  function automatic logic [7:0] byte_sel(input logic [MAX_INPUTS-1:0] word,
                                          input int unsigned           nbytes,
                                          input int unsigned           k);
    byte_sel = word[8*(nbytes-1-k) +: 8];
  endfunction

endpackage

// File: rtl/lif_neuron_loader_serializer.sv
// Byte serializer: latches a word and presents its bytes MSB first on a
// registered byte output, one per advance.
//   clk, reset : clock, asynchronous active-high reset
//   start      : latch word, present byte 0 next cycle
//   word       : word to serialize (INPUTS bits)
//   advance    : present the next byte (ignored on the last byte)
//   clear      : drive the byte output to zero
//   byte_out   : current byte (registered)
//   last       : byte_out currently holds the final byte
module lif_byte_serializer
  import lif_pkg::*;
#(
  parameter int unsigned INPUTS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [INPUTS-1:0] word,
  input  logic              advance,
  input  logic              clear,
  output logic [7:0]        byte_out,
  output logic              last
);

  localparam int unsigned NBYTES = INPUTS / 8;
  localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [INPUTS-1:0] word_q;
  logic [IDXW-1:0]   idx_q;
  logic [7:0]        byte_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
      byte_q <= '0;
    end else if (start) begin
      word_q <= word;
      idx_q  <= '0;
      byte_q <= byte_sel(MAX_INPUTS'(word), NBYTES, 0);
    end else if (advance && !last) begin
      idx_q  <= idx_q + 1'b1;
      byte_q <= byte_sel(MAX_INPUTS'(word_q), NBYTES, 32'(idx_q) + 32'd1);
    end else if (clear) begin
      byte_q <= '0;
    end
  end

  assign byte_out = byte_q;
  assign last     = (idx_q == IDXW'(NBYTES - 1));

endmodule

// File: rtl/lif_neuron_loader.sv
// Host-side driver for the LIF neuron's byte-serial load/run interface.
// Takes one command, shifts the weight word (optional) and input word into
// the neuron MSB byte first, releases it into run mode for cmd_run cycles,
// counts spikes (saturating) and holds the count until accepted.
//   clk, reset      : clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake (ready only in IDLE)
//   cmd_load_w      : load weights before inputs
//   cmd_weights     : weight word (1=+1, 0=-1)
//   cmd_inputs      : input spike word
//   cmd_run         : run-mode cycles to count
//   data_out        : byte bus to neuron ui_in
//   sel_weights     : neuron uio_in[0], 1 = byte targets weights
//   run_n           : neuron uio_in[1], 0 = load mode, 1 = run mode
//   spike_in        : neuron is_spike
//   res_valid/ready : result handshake
//   res_spikes      : spikes counted during RUN
module lif_neuron_loader
  import lif_pkg::*;
#(
  parameter int unsigned INPUTS     = 8 * BYTES,
  parameter int unsigned RUN_BITS   = 8,
  parameter int unsigned COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load_w,
  input  logic [INPUTS-1:0]     cmd_weights,
  input  logic [INPUTS-1:0]     cmd_inputs,
  input  logic [RUN_BITS-1:0]   cmd_run,
  output logic [7:0]            data_out,
  output logic                  sel_weights,
  output logic                  run_n,
  input  logic                  spike_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [COUNT_BITS-1:0] res_spikes
);

  state_t                state;
  logic [INPUTS-1:0]     inputs_q;
  logic [RUN_BITS-1:0]   run_left;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] count_next;
  logic                  cmd_ready_q;
  logic                  sel_q;
  logic                  run_n_q;
  logic                  res_valid_q;
  logic [COUNT_BITS-1:0] res_spikes_q;

  logic              ser_start;
  logic [INPUTS-1:0] ser_word;
  logic              ser_advance;
  logic              ser_clear;
  logic              ser_last;

  // The serializer registers data_out itself, so it is started on the same
  // edge the FSM enters a load state; byte 0 is on the bus in the first
  // load cycle and the weight->input handover has no gap.
  always_comb begin
    ser_start   = 1'b0;
    ser_word    = cmd_inputs;
    ser_advance = 1'b0;
    ser_clear   = 1'b0;
    case (state)
      IDLE: begin
        ser_start = cmd_valid;
        ser_word  = cmd_load_w ? cmd_weights : cmd_inputs;
      end
      LOAD_W: begin
        if (ser_last) begin
          ser_start = 1'b1;
          ser_word  = inputs_q;
        end else begin
          ser_advance = 1'b1;
        end
      end
      LOAD_I: begin
        if (ser_last) ser_clear   = 1'b1;
        else          ser_advance = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_next = count;
    if (spike_in && (count != '1)) count_next = count + 1'b1;
  end

  lif_byte_serializer #(
    .INPUTS (INPUTS)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (ser_start),
    .word     (ser_word),
    .advance  (ser_advance),
    .clear    (ser_clear),
    .byte_out (data_out),
    .last     (ser_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      inputs_q     <= '0;
      run_left     <= '0;
      count        <= '0;
      cmd_ready_q  <= 1'b1;
      sel_q        <= 1'b0;
      run_n_q      <= 1'b1;
      res_valid_q  <= 1'b0;
      res_spikes_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            inputs_q    <= cmd_inputs;
            run_left    <= cmd_run;
            count       <= '0;
            cmd_ready_q <= 1'b0;
            run_n_q     <= 1'b0;
            sel_q       <= cmd_load_w;
            state       <= cmd_load_w ? LOAD_W : LOAD_I;
          end
        end
        LOAD_W: begin
          if (ser_last) begin
            sel_q <= 1'b0;
            state <= LOAD_I;
          end
        end
        LOAD_I: begin
          if (ser_last) begin
            run_n_q <= 1'b1;
            if (run_left == '0) begin
              res_valid_q  <= 1'b1;
              res_spikes_q <= count;
              state        <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          count    <= count_next;
          run_left <= run_left - 1'b1;
          // Final RUN cycle: publish the count including this cycle's spike.
          if (run_left == RUN_BITS'(1)) begin
            res_valid_q  <= 1'b1;
            res_spikes_q <= count_next;
            state        <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign sel_weights = sel_q;
  assign run_n       = run_n_q;
  assign res_valid   = res_valid_q;
  assign res_spikes  = res_spikes_q;

endmodule

// File: tb/tb_lif_neuron_loader.sv
// Self-checking bench for lif_neuron_loader: expected load bytes and results
// are queued when a command is driven and compared as the DUT produces them.
module tb_lif_neuron_loader;

  localparam int unsigned INPUTS   = 32;
  localparam int unsigned RUN_BITS = 8;
  localparam int unsigned CB       = 3;
  localparam int unsigned NB       = INPUTS / 8;
  localparam int unsigned SAT      = (1 << CB) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_load_w;
  logic [INPUTS-1:0]   cmd_weights;
  logic [INPUTS-1:0]   cmd_inputs;
  logic [RUN_BITS-1:0] cmd_run;
  logic [7:0]          data_out;
  logic                sel_weights;
  logic                run_n;
  logic                spike_in;
  logic                res_valid;
  logic                res_ready;
  logic [CB-1:0]       res_spikes;

  lif_neuron_loader #(
    .INPUTS     (INPUTS),
    .RUN_BITS   (RUN_BITS),
    .COUNT_BITS (CB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load_w  (cmd_load_w),
    .cmd_weights (cmd_weights),
    .cmd_inputs  (cmd_inputs),
    .cmd_run     (cmd_run),
    .data_out    (data_out),
    .sel_weights (sel_weights),
    .run_n       (run_n),
    .spike_in    (spike_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_spikes  (res_spikes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned spikes;
    int unsigned lat;
  } res_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [8:0]  byte_q[$];  // {sel_weights, data_out}
  res_t        res_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one command and follow it to completion. mask bit j drives
  // spike_in in cycle j after the accept edge; stall = cycles res_ready
  // is held low after res_valid appears (with a competing cmd_valid).
  task automatic do_cmd(input logic lw, input logic [INPUTS-1:0] w,
                        input logic [INPUTS-1:0] in, input int unsigned run,
                        input logic [63:0] mask, input int unsigned stall);
    int unsigned L = NB * (lw ? 2 : 1);
    int unsigned sp = 0;
    int unsigned wait_c = 0;
    int unsigned j;
    bit          got_res = 0;
    logic [8:0]  b;
    res_t        r;
    logic [INPUTS-1:0] t;

    if (lw) for (int unsigned k = 0; k < NB; k++) begin
      t = w >> (8 * (NB - 1 - k));
      byte_q.push_back({1'b1, t[7:0]});
    end
    for (int unsigned k = 0; k < NB; k++) begin
      t = in >> (8 * (NB - 1 - k));
      byte_q.push_back({1'b0, t[7:0]});
    end
    for (int unsigned k = L + 1; k <= L + run; k++)
      if (k < 64 && mask[k]) sp++;
    res_q.push_back('{(sp > SAT) ? SAT : sp, L + run + 1});

    while (!cmd_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check("ready_wait", 64'(wait_c < 50), 64'd1);
    cmd_valid   = 1'b1;
    cmd_load_w  = lw;
    cmd_weights = w;
    cmd_inputs  = in;
    cmd_run     = RUN_BITS'(run);
    @(negedge clk);
    // Scramble the command fields: the DUT must work from its latched copy.
    cmd_valid   = 1'b0;
    cmd_load_w  = ~lw;
    cmd_weights = ~w;
    cmd_inputs  = ~in;
    cmd_run     = '1;

    for (j = 1; j <= L + run + 4; j++) begin
      spike_in = (j < 64) ? mask[j] : 1'b0;
      check("run_n", 64'(run_n), 64'(j > L));
      check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (j <= L) begin
        if (byte_q.size() == 0) check("byte_q_empty", 64'(j), 64'd0);
        else begin
          b = byte_q.pop_front();
          check("load_byte", 64'({sel_weights, data_out}), 64'(b));
        end
      end else begin
        check("bus_idle", 64'({sel_weights, data_out}), 64'd0);
      end
      if (res_valid) begin
        got_res = 1;
        if (res_q.size() == 0) check("res_q_empty", 64'(j), 64'd0);
        else begin
          r = res_q.pop_front();
          check("latency", 64'(j), 64'(r.lat));
          check("res_spikes", 64'(res_spikes), 64'(r.spikes));
        end
        break;
      end
      @(negedge clk);
    end
    spike_in = 1'b0;
    check("res_seen", 64'(got_res), 64'd1);

    cmd_valid = 1'b1;  // offered while result is pending: must not be taken
    for (int unsigned s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 64'(res_valid), 64'd1);
      check("stall_spikes", 64'(res_spikes), 64'(r.spikes));
      check("stall_ready", 64'(cmd_ready), 64'd0);
      check("stall_run_n", 64'(run_n), 64'd1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_valid", 64'(res_valid), 64'd0);
    check("post_ready", 64'(cmd_ready), 64'd1);
    check("post_run_n", 64'(run_n), 64'd1);
    check("post_queue", 64'(byte_q.size() + res_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] m;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_load_w  = 1'b0;
    cmd_weights = '0;
    cmd_inputs  = '0;
    cmd_run     = '0;
    spike_in    = 1'b0;
    res_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_run_n", 64'(run_n), 64'd1);
    check("rst_bus", 64'({sel_weights, data_out}), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_spikes", 64'(res_spikes), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of LOAD_I.
    cmd_valid  = 1'b1;
    cmd_load_w = 1'b0;
    cmd_inputs = 32'hDEAD_BEEF;
    cmd_run    = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("midload_run_n", 64'(run_n), 64'd0);
    check("midload_byte", 64'({sel_weights, data_out}), 64'h0AD);
    reset = 1'b1;
    #1;
    check("abort_run_n", 64'(run_n), 64'd1);
    check("abort_bus", 64'(data_out), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    check("abort_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_abort_run_n", 64'(run_n), 64'd1);
    check("after_abort_ready", 64'(cmd_ready), 64'd1);

    // Weights + inputs, no run.
    do_cmd(1'b1, 32'hFFFF_0000, 32'h1234_5678, 0, 64'd0, 0);

    // Inputs only, run=10; spikes in 3 IDLE cycles, a load cycle, 4 RUN
    // cycles (incl. first and last) and the DONE cycle.
    spike_in = 1'b1;
    repeat (3) @(negedge clk);
    spike_in = 1'b0;
    m = '0;
    m[2] = 1'b1; m[5] = 1'b1; m[7] = 1'b1; m[10] = 1'b1; m[14] = 1'b1; m[15] = 1'b1;
    do_cmd(1'b0, 32'h0, 32'hCAFE_F00D, 10, m, 0);

    // Saturation: 20 RUN cycles all spiking.
    do_cmd(1'b1, 32'h8001_7FFE, 32'h00FF_00FF, 20, '1, 0);

    // Result back-pressure with a competing command.
    m = '0;
    m[5] = 1'b1; m[6] = 1'b1;
    do_cmd(1'b0, 32'h0, 32'hA5C3_0F96, 3, m, 5);

    // Short inputs-only, no run.
    do_cmd(1'b0, 32'h0, 32'h0102_0304, 0, '1, 1);

    // A few randomized commands.
    for (int i = 0; i < 4; i++) begin
      m = {$urandom, $urandom};
      do_cmd(1'($urandom), $urandom, $urandom, $urandom_range(1, 30), m, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
